counter_src_sel: RTL and testbench

Input-conditioning front end for one `counter` instance. It selects the start, stop, din0 and din1 sources from the shared source pool: inner counter outputs, single triggers, global triggers and the two external pins. External pins are synchronised and glitch-filtered. Each selected source passes through a configurable edge detector, and the block delivers registered one-cycle pulses or levels that drive the counter's `counter_start`, `counter_stop`, `counter_din0` and `counter_din1`.

---
 rtl/counter_pkg.sv | 29 ++
 rtl/counter_edge_det.sv | 52 +++++
 rtl/counter_src_sel.sv | 131 +++++++++++++
 tb/tb_counter_src_sel.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter input-conditioning front end:
// edge-detector modes and the source-pool layout.
package counter_pkg;

    typedef enum logic [1:0] {
        EDGE_LEVEL = 2'b00,
        EDGE_RISE  = 2'b01,
        EDGE_FALL  = 2'b10,
        EDGE_BOTH  = 2'b11
    } edge_mode_e;

    // The pool starts with the COUNTER_NUM inner outputs; the other offsets are added to COUNTER_NUM.
    localparam int SRC_INNER      = 0;
    localparam int SRC_SINGLE_OFS = 0;
    localparam int SRC_GLOBAL_OFS = 4;
    localparam int SRC_EXT_A_OFS  = 8;
    localparam int SRC_EXT_B_OFS  = 9;
    localparam int SRC_EXTRA      = 10;

    function automatic logic edge_apply(edge_mode_e mode, logic cur, logic prev);
        case (mode)
            EDGE_LEVEL: return cur;
            EDGE_RISE:  return cur & ~prev;
            EDGE_FALL:  return ~cur & prev;
            default:    return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/counter_edge_det.sv
// One conditioning channel: picks a source from the pool, detects the
// configured edge and registers the result.
module counter_edge_det
    import counter_pkg::*;
#(
    parameter int SRC_NUM   = 14,
    parameter int SEL_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [SRC_NUM-1:0]   pool,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic [1:0]           edge_mode,
    output logic                 pulse
);

    logic                 cur;
    logic                 prev;
    logic                 primed;
    logic [SEL_WIDTH-1:0] sel_q;
    logic                 sel_changed;
    logic                 edge_val;

    // Indices past the end of the pool match nothing, so they read as 0.
    always_comb begin
        cur = 1'b0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (sel == SEL_WIDTH'(i)) cur = pool[i];
        end
    end

    assign sel_changed = (sel != sel_q);
    assign edge_val    = edge_apply(edge_mode_e'(edge_mode), cur, prev);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            prev   <= 1'b0;
            primed <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sel_q  <= sel;
            prev   <= cur;
            primed <= 1'b1;
            // The first sample after reset or a select change only seeds prev.
            pulse  <= enable & primed & ~sel_changed & edge_val;
        end
    end

endmodule

// File: rtl/counter_src_sel.sv
// Input-conditioning front end for one counter: builds the source pool,
// filters the external pins and drives four edge-detector channels.
module counter_src_sel
    import counter_pkg::*;
#(
    parameter int COUNTER_NUM = 4,
    parameter int SEL_WIDTH   = $clog2(COUNTER_NUM + 10)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic [COUNTER_NUM-1:0] i_inner_din,
    input  logic                   i_single_start_trigger,
    input  logic                   i_single_stop_trigger,
    input  logic                   i_single_clear_trigger,
    input  logic                   i_single_reset_trigger,
    input  logic                   i_global_start_trigger,
    input  logic                   i_global_stop_trigger,
    input  logic                   i_global_clear_trigger,
    input  logic                   i_global_reset_trigger,
    input  logic                   i_extern_din_a,
    input  logic                   i_extern_din_b,
    input  logic [3:0]             i_filt_len,
    input  logic [SEL_WIDTH-1:0]   i_src_sel_start,
    input  logic [SEL_WIDTH-1:0]   i_src_sel_stop,
    input  logic [SEL_WIDTH-1:0]   i_src_sel_din0,
    input  logic [SEL_WIDTH-1:0]   i_src_sel_din1,
    input  logic [1:0]             i_src_edge_start,
    input  logic [1:0]             i_src_edge_stop,
    input  logic [1:0]             i_src_edge_din0,
    input  logic [1:0]             i_src_edge_din1,
    output logic                   o_start,
    output logic                   o_stop,
    output logic                   o_din0,
    output logic                   o_din1,
    output logic                   o_extern_a_filt,
    output logic                   o_extern_b_filt
);

    localparam int SRC_NUM = COUNTER_NUM + SRC_EXTRA;

    logic [1:0]           pins;
    logic [1:0]           filt;
    logic [SRC_NUM-1:0]   pool;
    logic [SEL_WIDTH-1:0] sel_bus  [4];
    logic [1:0]           edge_bus [4];
    logic [3:0]           chan_out;

    assign pins = {i_extern_din_b, i_extern_din_a};

    for (genvar p = 0; p < 2; p++) begin : g_pin
        logic       sync1;
        logic       sync2;
        logic       f;
        logic [3:0] cnt;
        logic [4:0] cnt_inc;

        assign cnt_inc = {1'b0, cnt} + 5'd1;

        // A >= compare means a shortened filter length mid-count updates f at once.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                f     <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= pins[p];
                sync2 <= sync1;
                if (i_filt_len == 4'd0) begin
                    f   <= sync2;
                    cnt <= '0;
                end else if (sync2 != f) begin
                    if (cnt_inc >= {1'b0, i_filt_len}) begin
                        f   <= sync2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc[3:0];
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign filt[p] = f;
    end

    always_comb begin
        pool = '0;
        pool[SRC_INNER +: COUNTER_NUM] = i_inner_din;
        pool[COUNTER_NUM + SRC_SINGLE_OFS +: 4] = {i_single_reset_trigger, i_single_clear_trigger,
                                                   i_single_stop_trigger,  i_single_start_trigger};
        pool[COUNTER_NUM + SRC_GLOBAL_OFS +: 4] = {i_global_reset_trigger, i_global_clear_trigger,
                                                   i_global_stop_trigger,  i_global_start_trigger};
        pool[COUNTER_NUM + SRC_EXT_A_OFS] = filt[0];
        pool[COUNTER_NUM + SRC_EXT_B_OFS] = filt[1];
    end

    assign sel_bus[0]  = i_src_sel_start;
    assign sel_bus[1]  = i_src_sel_stop;
    assign sel_bus[2]  = i_src_sel_din0;
    assign sel_bus[3]  = i_src_sel_din1;
    assign edge_bus[0] = i_src_edge_start;
    assign edge_bus[1] = i_src_edge_stop;
    assign edge_bus[2] = i_src_edge_din0;
    assign edge_bus[3] = i_src_edge_din1;

    for (genvar ch = 0; ch < 4; ch++) begin : g_chan
        counter_edge_det #(
            .SRC_NUM   (SRC_NUM),
            .SEL_WIDTH (SEL_WIDTH)
        ) u_edge_det (
            .clk       (i_clk),
            .rst_n     (i_rst_n),
            .enable    (i_enable),
            .pool      (pool),
            .sel       (sel_bus[ch]),
            .edge_mode (edge_bus[ch]),
            .pulse     (chan_out[ch])
        );
    end

    assign o_start         = chan_out[0];
    assign o_stop          = chan_out[1];
    assign o_din0          = chan_out[2];
    assign o_din1          = chan_out[3];
    assign o_extern_a_filt = filt[0];
    assign o_extern_b_filt = filt[1];

endmodule

// File: tb/tb_counter_src_sel.sv
// Self-checking bench for counter_src_sel: directed scenarios plus a random
// phase, all compared against a cycle-level behavioural model.
module tb_counter_src_sel;

    localparam int N  = 4;
    localparam int SW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_enable;
    logic [N-1:0]  i_inner_din;
    logic          i_single_start_trigger, i_single_stop_trigger;
    logic          i_single_clear_trigger, i_single_reset_trigger;
    logic          i_global_start_trigger, i_global_stop_trigger;
    logic          i_global_clear_trigger, i_global_reset_trigger;
    logic          i_extern_din_a, i_extern_din_b;
    logic [3:0]    i_filt_len;
    logic [SW-1:0] i_src_sel_start, i_src_sel_stop, i_src_sel_din0, i_src_sel_din1;
    logic [1:0]    i_src_edge_start, i_src_edge_stop, i_src_edge_din0, i_src_edge_din1;
    logic          o_start, o_stop, o_din0, o_din1, o_extern_a_filt, o_extern_b_filt;

    counter_src_sel #(.COUNTER_NUM(N), .SEL_WIDTH(SW)) dut (
        .i_clk                  (i_clk),
        .i_rst_n                (i_rst_n),
        .i_enable               (i_enable),
        .i_inner_din            (i_inner_din),
        .i_single_start_trigger (i_single_start_trigger),
        .i_single_stop_trigger  (i_single_stop_trigger),
        .i_single_clear_trigger (i_single_clear_trigger),
        .i_single_reset_trigger (i_single_reset_trigger),
        .i_global_start_trigger (i_global_start_trigger),
        .i_global_stop_trigger  (i_global_stop_trigger),
        .i_global_clear_trigger (i_global_clear_trigger),
        .i_global_reset_trigger (i_global_reset_trigger),
        .i_extern_din_a         (i_extern_din_a),
        .i_extern_din_b         (i_extern_din_b),
        .i_filt_len             (i_filt_len),
        .i_src_sel_start        (i_src_sel_start),
        .i_src_sel_stop         (i_src_sel_stop),
        .i_src_sel_din0         (i_src_sel_din0),
        .i_src_sel_din1         (i_src_sel_din1),
        .i_src_edge_start       (i_src_edge_start),
        .i_src_edge_stop        (i_src_edge_stop),
        .i_src_edge_din0        (i_src_edge_din0),
        .i_src_edge_din1        (i_src_edge_din1),
        .o_start                (o_start),
        .o_stop                 (o_stop),
        .o_din0                 (o_din0),
        .o_din1                 (o_din1),
        .o_extern_a_filt        (o_extern_a_filt),
        .o_extern_b_filt        (o_extern_b_filt)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: pin delay line, filter level and run length, per-channel history.
    logic m_s1[2], m_s2[2], m_f[2];
    int   m_run[2];
    logic m_prev[4], m_primed[4], m_out[4];
    int   m_selq[4];

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_s1[p] = 1'b0; m_s2[p] = 1'b0; m_f[p] = 1'b0; m_run[p] = 0;
        end
        for (int c = 0; c < 4; c++) begin
            m_prev[c] = 1'b0; m_primed[c] = 1'b0; m_out[c] = 1'b0; m_selq[c] = 0;
        end
    endtask

    function automatic logic model_src(int idx);
        logic pool[N+10];
        for (int k = 0; k < N; k++) pool[k] = i_inner_din[k];
        pool[N+0] = i_single_start_trigger;
        pool[N+1] = i_single_stop_trigger;
        pool[N+2] = i_single_clear_trigger;
        pool[N+3] = i_single_reset_trigger;
        pool[N+4] = i_global_start_trigger;
        pool[N+5] = i_global_stop_trigger;
        pool[N+6] = i_global_clear_trigger;
        pool[N+7] = i_global_reset_trigger;
        pool[N+8] = m_f[0];
        pool[N+9] = m_f[1];
        return (idx < N + 10) ? pool[idx] : 1'b0;
    endfunction

    // Advances the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        int   sels[4];
        int   modes[4];
        logic cur;
        logic pins[2];
        sels[0] = int'(i_src_sel_start);   modes[0] = int'(i_src_edge_start);
        sels[1] = int'(i_src_sel_stop);    modes[1] = int'(i_src_edge_stop);
        sels[2] = int'(i_src_sel_din0);    modes[2] = int'(i_src_edge_din0);
        sels[3] = int'(i_src_sel_din1);    modes[3] = int'(i_src_edge_din1);
        for (int c = 0; c < 4; c++) begin
            cur = model_src(sels[c]);
            if (!i_enable || !m_primed[c] || sels[c] != m_selq[c]) m_out[c] = 1'b0;
            else begin
                case (modes[c])
                    0:       m_out[c] = cur;
                    1:       m_out[c] = cur && !m_prev[c];
                    2:       m_out[c] = !cur && m_prev[c];
                    default: m_out[c] = (cur != m_prev[c]);
                endcase
            end
            m_prev[c]   = cur;
            m_selq[c]   = sels[c];
            m_primed[c] = 1'b1;
        end
        pins[0] = i_extern_din_a;
        pins[1] = i_extern_din_b;
        for (int p = 0; p < 2; p++) begin
            if (i_filt_len == 0) begin
                m_f[p] = m_s2[p]; m_run[p] = 0;
            end else if (m_s2[p] != m_f[p]) begin
                m_run[p]++;
                if (m_run[p] >= int'(i_filt_len)) begin
                    m_f[p] = m_s2[p]; m_run[p] = 0;
                end
            end else begin
                m_run[p] = 0;
            end
            m_s2[p] = m_s1[p];
            m_s1[p] = pins[p];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
        cyc++;
        check("o_start", o_start, m_out[0]);
        check("o_stop",  o_stop,  m_out[1]);
        check("o_din0",  o_din0,  m_out[2]);
        check("o_din1",  o_din1,  m_out[3]);
        check("o_extern_a_filt", o_extern_a_filt, m_f[0]);
        check("o_extern_b_filt", o_extern_b_filt, m_f[1]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, o_start, 1'b0);
        check({tag, "_stop"},  o_stop,  1'b0);
        check({tag, "_din0"},  o_din0,  1'b0);
        check({tag, "_din1"},  o_din1,  1'b0);
        check({tag, "_fa"},    o_extern_a_filt, 1'b0);
        check({tag, "_fb"},    o_extern_b_filt, 1'b0);
    endtask

    initial begin
        int first_at;
        int pulses;

        i_rst_n = 1'b0;
        i_enable = 1'b1;
        i_inner_din = '0;
        {i_single_start_trigger, i_single_stop_trigger, i_single_clear_trigger, i_single_reset_trigger} = '0;
        {i_global_start_trigger, i_global_stop_trigger, i_global_clear_trigger, i_global_reset_trigger} = '0;
        i_extern_din_a = 1'b0;
        i_extern_din_b = 1'b0;
        i_filt_len = 4'd0;
        i_src_sel_start = 4'd15; i_src_sel_stop = 4'd15; i_src_sel_din0 = 4'd15; i_src_sel_din1 = 4'd15;
        i_src_edge_start = 2'b00; i_src_edge_stop = 2'b00; i_src_edge_din0 = 2'b00; i_src_edge_din1 = 2'b00;
        model_reset();

        // Reset state
        #12;
        check_all_zero("reset");
        #10;
        i_rst_n = 1'b1;
        repeat (3) tick();

        // Inner-din rising edge: one-cycle pulse one cycle after the change
        i_src_sel_start = 4'd1; i_src_edge_start = 2'b01;
        repeat (3) tick();
        i_inner_din = 4'b0010;
        tick();
        check("inner_rise_pulse", o_start, 1'b1);
        tick();
        check("inner_rise_single", o_start, 1'b0);
        repeat (2) tick();

        // Extern-b both edges through a length-3 filter
        i_src_sel_din0 = 4'd13; i_src_edge_din0 = 2'b11; i_filt_len = 4'd3;
        repeat (3) tick();
        i_extern_din_b = 1'b1;
        pulses = 0;
        repeat (2) begin tick(); pulses += int'(o_din0); end
        i_extern_din_b = 1'b0;
        repeat (8) begin tick(); pulses += int'(o_din0); end
        check_int("glitch_dropped", pulses, 0);
        i_extern_din_b = 1'b1;
        first_at = 0; pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (o_din0) begin pulses++; if (first_at == 0) first_at = k; end
        end
        check_int("extb_rise_latency", first_at, 6);
        check_int("extb_rise_count", pulses, 1);
        i_extern_din_b = 1'b0;
        first_at = 0; pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (o_din0) begin pulses++; if (first_at == 0) first_at = k; end
        end
        check_int("extb_fall_latency", first_at, 6);
        check_int("extb_fall_count", pulses, 1);

        // Select change onto a source that is already high: no false edge
        i_src_sel_stop = 4'd4; i_src_edge_stop = 2'b01;
        repeat (2) tick();
        i_global_start_trigger = 1'b1;
        repeat (2) tick();
        i_src_sel_stop = 4'd8;
        tick();
        check("selchg_suppress", o_stop, 1'b0);
        tick();
        check("selchg_no_edge", o_stop, 1'b0);
        i_global_start_trigger = 1'b0;
        tick();
        i_global_start_trigger = 1'b1;
        tick();
        check("selchg_next_rise", o_stop, 1'b1);
        tick();

        // Enable gating: prev tracks the source while disabled
        i_src_sel_start = 4'd5; i_src_edge_start = 2'b01;
        repeat (2) tick();
        i_enable = 1'b0;
        repeat (3) begin
            i_single_stop_trigger = 1'b1; tick();
            check("disabled_start", o_start, 1'b0);
            i_single_stop_trigger = 1'b0; tick();
        end
        i_single_stop_trigger = 1'b1;
        tick();
        i_enable = 1'b1;
        repeat (3) begin
            tick();
            check("reenable_no_pulse", o_start, 1'b0);
        end

        // Out-of-range index reads 0; then level mode on single_start
        i_src_sel_din1 = 4'd15; i_src_edge_din1 = 2'b00;
        repeat (8) begin
            i_inner_din = 4'($urandom);
            {i_single_start_trigger, i_single_clear_trigger, i_global_stop_trigger} = 3'($urandom);
            tick();
            check("oor_zero", o_din1, 1'b0);
        end
        i_inner_din = '0;
        {i_single_start_trigger, i_single_clear_trigger, i_global_stop_trigger} = '0;
        i_src_sel_din1 = 4'd4;
        repeat (2) tick();
        i_single_start_trigger = 1'b1;
        tick();
        check("level_high", o_din1, 1'b1);
        tick();
        check("level_hold", o_din1, 1'b1);
        i_single_start_trigger = 1'b0;
        tick();
        check("level_low", o_din1, 1'b0);

        // Reset in the middle of a filter count
        i_src_sel_start = 4'd8; i_src_edge_start = 2'b00;
        i_global_start_trigger = 1'b1;
        repeat (2) tick();
        check("pre_reset_level", o_start, 1'b1);
        i_src_sel_din1 = 4'd12; i_src_edge_din1 = 2'b01; i_filt_len = 4'd5;
        i_extern_din_a = 1'b1;
        repeat (4) tick();
        i_extern_din_a = 1'b0;
        i_src_edge_start = 2'b01;
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        #20;
        i_rst_n = 1'b1;
        model_reset();
        repeat (8) begin
            tick();
            check("post_reset_start", o_start, 1'b0);
            check("post_reset_stop",  o_stop,  1'b0);
            check("post_reset_din0",  o_din0,  1'b0);
            check("post_reset_din1",  o_din1,  1'b0);
        end

        // Random phase against the model
        for (int n = 0; n < 600; n++) begin
            i_inner_din = 4'($urandom);
            {i_single_start_trigger, i_single_stop_trigger, i_single_clear_trigger, i_single_reset_trigger} = 4'($urandom);
            {i_global_start_trigger, i_global_stop_trigger, i_global_clear_trigger, i_global_reset_trigger} = 4'($urandom);
            if ($urandom_range(0, 5) == 0) i_extern_din_a = ~i_extern_din_a;
            if ($urandom_range(0, 5) == 0) i_extern_din_b = ~i_extern_din_b;
            if ($urandom_range(0, 15) == 0) i_src_sel_start = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) i_src_sel_stop  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) i_src_sel_din0  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) i_src_sel_din1  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) i_src_edge_start = 2'($urandom);
            if ($urandom_range(0, 15) == 0) i_src_edge_stop  = 2'($urandom);
            if ($urandom_range(0, 15) == 0) i_src_edge_din0  = 2'($urandom);
            if ($urandom_range(0, 15) == 0) i_src_edge_din1  = 2'($urandom);
            if ($urandom_range(0, 31) == 0) i_filt_len = 4'($urandom_range(0, 6));
            i_enable = ($urandom_range(0, 15) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
